// File: rtl/ifx_dig_data_bus_mst_arb.sv
// ifx_dig_data_bus_mst_arb
// Round-robin master for the digital data bus. NCH clients request read/write
// accesses over valid/ready; one access at a time is driven on the bus and a
// one-cycle response pulse is returned to the granted channel.
// Optional feature: define IFX_DIG_DATA_BUS_ADDR_CHK_EN to reject accepted
// requests with addr > MAX_ADDR (no bus access, error response in cycle 1).
module ifx_dig_data_bus_mst_arb #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 16,
  parameter int NCH    = 4,
  parameter int RD_LAT = 1,
  parameter logic [AWIDTH-1:0] MAX_ADDR = {AWIDTH{1'b1}}
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [NCH-1:0]        req_valid_i,
  output logic [NCH-1:0]        req_ready_o,
  input  logic [NCH-1:0]        req_wr_i,
  input  logic [NCH*AWIDTH-1:0] req_addr_i,
  input  logic [NCH*DWIDTH-1:0] req_wdata_i,
  output logic [NCH-1:0]        rsp_valid_o,
  output logic [DWIDTH-1:0]     rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic                  acc_en_o,
  output logic                  wr_en_o,
  output logic [AWIDTH-1:0]     addr_o,
  output logic [DWIDTH-1:0]     wdata_o,
  input  logic [DWIDTH-1:0]     rdata_i
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [NCH-1:0]  cap_sel_q;   // one-hot channel of the access in flight
  logic            cap_wr_q;
  logic [2:0]      wait_cnt_q;

  logic [NCH-1:0]    grant;
  logic [PW-1:0]     grant_idx;
  logic              grant_any;
  int unsigned       scan_idx;
  logic [PW-1:0]     next_ptr;
  logic              sel_wr;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;

  // Round-robin search: first valid channel at or above ptr_q, with wrap.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = 0;
    for (int i = 0; i < NCH; i++) begin
      scan_idx = (int'(ptr_q) + i) % NCH;
      if (!grant_any && req_valid_i[scan_idx]) begin
        grant_any          = 1'b1;
        grant[scan_idx]    = 1'b1;
        grant_idx          = PW'(scan_idx);
      end
    end
  end

  assign next_ptr    = (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + 1'b1;
  assign sel_wr      = req_wr_i[grant_idx];
  assign sel_addr    = req_addr_i[int'(grant_idx)*AWIDTH +: AWIDTH];
  assign sel_wdata   = req_wdata_i[int'(grant_idx)*DWIDTH +: DWIDTH];

  // Grants are only offered while idle; valid&ready therefore equals grant.
  assign req_ready_o = (state_q == ST_IDLE) ? grant : '0;
  assign busy_o      = (state_q != ST_IDLE);

`ifdef IFX_DIG_DATA_BUS_ADDR_CHK_EN
  logic addr_bad;
  logic err_q;
  assign addr_bad  = (sel_addr > MAX_ADDR);
  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  // Access sequencer: accept, drive one bus cycle, wait for read data, respond.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cap_sel_q   <= '0;
      cap_wr_q    <= 1'b0;
      wait_cnt_q  <= '0;
      acc_en_o    <= 1'b0;
      wr_en_o     <= 1'b0;
      addr_o      <= '0;
      wdata_o     <= '0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
`ifdef IFX_DIG_DATA_BUS_ADDR_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      // Bus and response outputs are single-cycle strobes; default them low.
      acc_en_o    <= 1'b0;
      wr_en_o     <= 1'b0;
      addr_o      <= '0;
      wdata_o     <= '0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
`ifdef IFX_DIG_DATA_BUS_ADDR_CHK_EN
      err_q       <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            cap_sel_q <= grant;
            cap_wr_q  <= sel_wr;
            ptr_q     <= next_ptr;
`ifdef IFX_DIG_DATA_BUS_ADDR_CHK_EN
            if (addr_bad) begin
              state_q     <= ST_RESP;
              rsp_valid_o <= grant;
              err_q       <= 1'b1;
            end else begin
              state_q  <= ST_ACCESS;
              acc_en_o <= 1'b1;
              wr_en_o  <= sel_wr;
              addr_o   <= sel_addr;
              wdata_o  <= sel_wr ? sel_wdata : '0;
            end
`else
            state_q  <= ST_ACCESS;
            acc_en_o <= 1'b1;
            wr_en_o  <= sel_wr;
            addr_o   <= sel_addr;
            wdata_o  <= sel_wr ? sel_wdata : '0;
`endif
          end
        end
        ST_ACCESS: begin
          if (cap_wr_q) begin
            state_q     <= ST_RESP;
            rsp_valid_o <= cap_sel_q;
          end else begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= '0;
          end
        end
        ST_WAIT: begin
          // Read data is valid RD_LAT cycles after acc_en; capture on the last one.
          if (wait_cnt_q == 3'(RD_LAT - 1)) begin
            state_q     <= ST_RESP;
            rsp_valid_o <= cap_sel_q;
            rsp_rdata_o <= rdata_i;
          end else begin
            wait_cnt_q <= wait_cnt_q + 3'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifx_dig_data_bus_mst_arb.sv
// Directed self-checking bench for ifx_dig_data_bus_mst_arb
// (NCH=4, AWIDTH=8, DWIDTH=16, RD_LAT=2, MAX_ADDR=0x3F).
module tb_ifx_dig_data_bus_mst_arb;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NC = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic [NC-1:0]  req_valid;
  logic [NC-1:0]  req_ready;
  logic [NC-1:0]  req_wr;
  logic [NC*AW-1:0] req_addr;
  logic [NC*DW-1:0] req_wdata;
  logic [NC-1:0]  rsp_valid;
  logic [DW-1:0]  rsp_rdata;
  logic           rsp_err;
  logic           busy;
  logic           acc_en;
  logic           wr_en;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  wdata;
  logic [DW-1:0]  rdata;

  int n_tests = 0;
  int n_fail  = 0;

  ifx_dig_data_bus_mst_arb #(
    .AWIDTH(AW), .DWIDTH(DW), .NCH(NC), .RD_LAT(2), .MAX_ADDR(8'h3F)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_wr_i    (req_wr),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .acc_en_o    (acc_en),
    .wr_en_o     (wr_en),
    .addr_o      (addr),
    .wdata_o     (wdata),
    .rdata_i     (rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr[ch]            = wr;
    req_addr[ch*AW +: AW] = a;
    req_wdata[ch*DW +: DW] = d;
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    rdata     = '0;

    // Reset state
    #1;
    check("rst_acc_en", acc_en, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_addr", addr, 0);
    step();
    step();
    rstn = 1'b1;
    step();

    // Test 1: reset asserted while a read sits in WAIT
    set_req(0, 1'b0, 8'h05, 16'h0000);
    req_valid = 4'b0001;
    #1;
    check("t1_ready", req_ready, 4'b0001);
    step();                                  // cycle 1: ACCESS
    req_valid = '0;
    check("t1_acc_en", acc_en, 1);
    step();                                  // cycle 2: WAIT
    check("t1_busy_wait", busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("t1_rst_busy", busy, 0);
    check("t1_rst_acc_en", acc_en, 0);
    check("t1_rst_addr", addr, 0);
    check("t1_rst_rsp", rsp_valid, 0);
    step();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t1_no_rsp", rsp_valid, 0);
      check("t1_idle", busy, 0);
    end

    // Test 2: ch1 write (ptr=0)
    set_req(1, 1'b1, 8'h12, 16'h00A5);
    req_valid = 4'b0010;
    #1;
    check("t2_ready", req_ready, 4'b0010);
    step();                                  // cycle 1
    req_valid = '0;
    check("t2_acc_en", acc_en, 1);
    check("t2_wr_en", wr_en, 1);
    check("t2_addr", addr, 8'h12);
    check("t2_wdata", wdata, 16'h00A5);
    check("t2_ready_busy", req_ready, 0);
    step();                                  // cycle 2
    check("t2_rsp_valid", rsp_valid, 4'b0010);
    check("t2_rsp_rdata", rsp_rdata, 0);
    check("t2_rsp_err", rsp_err, 0);
    check("t2_acc_off", acc_en, 0);
    step();                                  // cycle 3
    check("t2_rsp_clr", rsp_valid, 0);
    check("t2_busy_clr", busy, 0);

    // Test 3: ch0 read, RD_LAT=2 (ptr=2, wraps to ch0)
    set_req(0, 1'b0, 8'h05, 16'h1234);
    req_valid = 4'b0001;
    #1;
    check("t3_ready", req_ready, 4'b0001);
    step();                                  // cycle 1
    req_valid = '0;
    check("t3_acc_en", acc_en, 1);
    check("t3_wr_en", wr_en, 0);
    check("t3_addr", addr, 8'h05);
    check("t3_wdata_zero", wdata, 0);
    step();                                  // cycle 2
    rdata = 16'hBEEF;
    check("t3_acc_off", acc_en, 0);
    check("t3_no_rsp_c2", rsp_valid, 0);
    step();                                  // cycle 3
    check("t3_no_rsp_c3", rsp_valid, 0);
    step();                                  // cycle 4
    rdata = 16'h0000;
    check("t3_rsp_valid", rsp_valid, 4'b0001);
    check("t3_rsp_rdata", rsp_rdata, 16'hBEEF);
    step();                                  // cycle 5
    check("t3_rsp_clr", rsp_valid, 0);
    check("t3_rdata_clr", rsp_rdata, 0);

    // Test 4: all channels valid, 8 writes from ptr=0
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    for (int c = 0; c < NC; c++) set_req(c, 1'b1, AW'(c + 8'h20), DW'(c));
    req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < 10 && req_ready == '0; b++) begin
        step();
        check("t4_onehot0", 32'($onehot0(req_ready)), 1);
      end
      if (req_ready == '0) begin
        check("t4_grant_timeout", 0, 1);
      end else begin
        check("t4_grant", req_ready, 4'b0001 << (i % 4));
      end
      step();
      check("t4_onehot0", 32'($onehot0(req_ready)), 1);
    end
    req_valid = '0;
    step();
    step();
    check("t4_idle", busy, 0);

    // Test 5: ch2 drops valid before grant; ch3 served next (ptr=0)
    set_req(0, 1'b1, 8'h01, 16'h0011);
    set_req(2, 1'b1, 8'h02, 16'h0022);
    set_req(3, 1'b1, 8'h03, 16'h0033);
    req_valid = 4'b0001;
    #1;
    check("t5_ready_ch0", req_ready, 4'b0001);
    step();                                  // cycle 1
    req_valid = 4'b1100;
    #1;
    check("t5_no_ready_busy", req_ready, 0);
    step();                                  // cycle 2
    check("t5_rsp_ch0", rsp_valid, 4'b0001);
    req_valid = 4'b1000;
    step();                                  // cycle 3
    check("t5_ready_ch3", req_ready, 4'b1000);
    step();                                  // cycle 4
    req_valid = '0;
    check("t5_acc_en", acc_en, 1);
    check("t5_addr", addr, 8'h03);
    step();                                  // cycle 5
    check("t5_rsp_ch3", rsp_valid, 4'b1000);
    step();
    check("t5_rsp_clr", rsp_valid, 0);
    check("t5_idle", busy, 0);

    // Test 6: out-of-range read on ch1 (ptr=0)
    set_req(1, 1'b0, 8'h40, 16'h0000);
    req_valid = 4'b0010;
    #1;
    check("t6_ready", req_ready, 4'b0010);
    step();                                  // cycle 1
    req_valid = '0;
`ifdef IFX_DIG_DATA_BUS_ADDR_CHK_EN
    check("t6_acc_off", acc_en, 0);
    check("t6_rsp_valid", rsp_valid, 4'b0010);
    check("t6_rsp_err", rsp_err, 1);
    check("t6_rsp_rdata", rsp_rdata, 0);
    step();
    check("t6_acc_off2", acc_en, 0);
    check("t6_err_clr", rsp_err, 0);
    check("t6_idle", busy, 0);
`else
    check("t6_acc_en", acc_en, 1);
    check("t6_wr_en", wr_en, 0);
    check("t6_addr", addr, 8'h40);
    step();                                  // cycle 2
    rdata = 16'h5A5A;
    step();                                  // cycle 3
    step();                                  // cycle 4
    rdata = 16'h0000;
    check("t6_rsp_valid", rsp_valid, 4'b0010);
    check("t6_rsp_rdata", rsp_rdata, 16'h5A5A);
    check("t6_rsp_err", rsp_err, 0);
    step();
    check("t6_idle", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
